// File: rtl/logic_sharing_pkg.sv
// Shared types and helpers for the shared-logic capture stage.
package logic_sharing_pkg;

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned SLOT_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Word record layout inside the FIFO, MSB to LSB: {sel, len, data}.
    function automatic int unsigned word_data_w(input int unsigned spw);
        return SLOT_W * spw;
    endfunction

    function automatic int unsigned word_len_w(input int unsigned spw);
        return $clog2(spw + 1);
    endfunction

    function automatic int unsigned word_w(input int unsigned spw);
        return SEL_W + word_len_w(spw) + word_data_w(spw);
    endfunction

    // One sample occupies a 2-bit slot as {y,x}.
    function automatic logic [SLOT_W-1:0] pack_slot(input logic x, input logic y);
        return {y, x};
    endfunction

endpackage

// File: rtl/logic_sharing_capture_sync_fifo.sv
// Synchronous FIFO with occupancy count; storage clears on reset so head reads 0.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage write, power-of-two pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
    end

    // Read pointer and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/logic_sharing_capture.sv
// Capture stage: packs {y,x} samples into select-tagged words, buffers them, counts hits.
module logic_sharing_capture
    import logic_sharing_pkg::*;
#(
    parameter int unsigned SPW   = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     x,
    input  logic                     y,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*SPW-1:0]         out_data,
    output logic [$clog2(SPW+1)-1:0] out_len,
    output logic [SEL_W-1:0]         out_sel,
    output logic [CNT_W-1:0]         x_count,
    output logic [CNT_W-1:0]         y_count
);

    localparam int unsigned DATA_W = word_data_w(SPW);
    localparam int unsigned LEN_W  = word_len_w(SPW);
    localparam int unsigned IDX_W  = $clog2(SPW);
    localparam int unsigned WORD_W = word_w(SPW);
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
    logic [SEL_W-1:0]  r_cur_sel,  w_sel_nxt;
    logic [DATA_W-1:0] r_partial,  w_partial_nxt;
    logic              r_nonempty, w_nonempty_nxt;
    logic [CNT_W-1:0]  r_x_count;
    logic [CNT_W-1:0]  r_y_count;

    logic              w_accept;
    logic              w_flush;
    logic [DATA_W-1:0] w_slot0;
    logic [DATA_W-1:0] w_filled;
    logic              w_push;
    logic [WORD_W-1:0] w_push_word;
    logic              w_pop;
    logic [WORD_W-1:0] w_head;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign in_ready  = !w_fifo_full;
    assign out_valid = (w_fifo_count != '0);
    assign w_pop     = out_ready && !w_fifo_empty;
    assign w_accept  = in_valid && in_ready;
    assign w_flush   = flush && in_ready;
    assign w_slot0   = DATA_W'(pack_slot(x, y));
    assign w_filled  = r_partial | (w_slot0 << {r_idx, 1'b0});

    assign out_data  = w_head[DATA_W-1:0];
    assign out_len   = w_head[DATA_W +: LEN_W];
    assign out_sel   = w_head[DATA_W+LEN_W +: SEL_W];
    assign x_count   = r_x_count;
    assign y_count   = r_y_count;

    // Word assembler next state and word-close decision (at most one push per cycle).
    always_comb begin
        w_push         = 1'b0;
        w_push_word    = '0;
        w_idx_nxt      = r_idx;
        w_sel_nxt      = r_cur_sel;
        w_partial_nxt  = r_partial;
        w_nonempty_nxt = r_nonempty;
        if (w_accept && r_nonempty && (sel != r_cur_sel)) begin
            // Tag change closes the old word; a coincident flush is consumed by it.
            w_push         = 1'b1;
            w_push_word    = {r_cur_sel, LEN_W'(r_idx), r_partial};
            w_partial_nxt  = w_slot0;
            w_idx_nxt      = IDX_W'(1);
            w_sel_nxt      = sel;
            w_nonempty_nxt = 1'b1;
        end else if (w_accept) begin
            w_sel_nxt = sel;
            if ((r_idx == IDX_W'(SPW - 1)) || w_flush) begin
                w_push         = 1'b1;
                w_push_word    = {sel, LEN_W'(r_idx) + LEN_W'(1), w_filled};
                w_partial_nxt  = '0;
                w_idx_nxt      = '0;
                w_nonempty_nxt = 1'b0;
            end else begin
                w_partial_nxt  = w_filled;
                w_idx_nxt      = r_idx + IDX_W'(1);
                w_nonempty_nxt = 1'b1;
            end
        end else if (w_flush && r_nonempty) begin
            w_push         = 1'b1;
            w_push_word    = {r_cur_sel, LEN_W'(r_idx), r_partial};
            w_partial_nxt  = '0;
            w_idx_nxt      = '0;
            w_nonempty_nxt = 1'b0;
        end
    end

    // Word assembler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cur_sel  <= '0;
            r_partial  <= '0;
            r_nonempty <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_cur_sel  <= w_sel_nxt;
            r_partial  <= w_partial_nxt;
            r_nonempty <= w_nonempty_nxt;
        end
    end

    // Saturating hit counters over accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_count <= '0;
            r_y_count <= '0;
        end else if (w_accept) begin
            if (x && (r_x_count != '1)) r_x_count <= r_x_count + CNT_W'(1);
            if (y && (r_y_count != '1)) r_y_count <= r_y_count + CNT_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_logic_sharing_capture.sv
// Scoreboard bench for logic_sharing_capture: directed words queued, monitor compares on pop.
module tb_logic_sharing_capture;

    typedef struct {
        logic [7:0] d;
        logic [2:0] len;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, x = 1'b0, y = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] out_len;
    logic [1:0] out_sel;
    logic [7:0] x_count, y_count;

    logic       s_in_valid = 1'b0, s_x = 1'b0, s_y = 1'b0, s_flush = 1'b0, s_out_ready = 1'b1;
    logic [1:0] s_sel = 2'b00;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_data;
    logic [2:0] s_out_len;
    logic [1:0] s_out_sel;
    logic [2:0] s_x_count, s_y_count;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_x = 0;
    int   exp_y = 0;

    always #5 clk = ~clk;

    logic_sharing_capture dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .sel(sel), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
        .out_sel(out_sel), .x_count(x_count), .y_count(y_count)
    );

    logic_sharing_capture #(.SPW(4), .DEPTH(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .x(s_x), .y(s_y), .sel(s_sel), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_len(s_out_len),
        .out_sel(s_out_sel), .x_count(s_x_count), .y_count(s_y_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [7:0] d, input logic [2:0] len, input logic [1:0] s);
        exp_t e;
        e.d = d; e.len = len; e.sel = s;
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus starting #1 after a rising edge.
    task automatic send(input logic [1:0] s, input logic xi, input logic yi,
                        input logic fl, input bit acc);
        in_valid = 1'b1; sel = s; x = xi; y = yi; flush = fl;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        if (acc) begin
            exp_x += int'(xi);
            exp_y += int'(yi);
        end
    endtask

    task automatic do_flush();
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        #1;
        out_ready = 1'b0;
        check({name, "_queue_left"}, 32'(q.size()), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Monitor: compare every popped head against the scoreboard front.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data=%0h len=%0d sel=%0d, none expected",
                         out_data, out_len, out_sel);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("word_data", 32'(out_data), 32'(e.d));
                check("word_len", 32'(out_len), 32'(e.len));
                check("word_sel", 32'(out_sel), 32'(e.sel));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       xi, yi;

        // Reset values.
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_len", 32'(out_len), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_x_count", 32'(x_count), 32'd0);
        check("rst_y_count", 32'(y_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Pack four samples into one full word.
        expect_word(8'b11_10_01_00, 3'd4, 2'b01);
        send(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        send(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        check("pack_not_yet_valid", 32'(out_valid), 32'd0);
        send(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        check("pack_out_valid", 32'(out_valid), 32'd1);
        check("pack_x_count", 32'(x_count), 32'd2);
        check("pack_y_count", 32'(y_count), 32'd2);
        drain("pack");

        // Select change closes a partial word, then flush closes the 1-sample word.
        expect_word(8'h0F, 3'd2, 2'b01);
        expect_word(8'h00, 3'd1, 2'b11);
        send(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        send(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        send(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        check("selchg_out_valid", 32'(out_valid), 32'd1);
        do_flush();
        do_flush();
        check("selchg_x_count", 32'(x_count), 32'(exp_x));
        drain("selchg");

        // Flush together with a matching-sel accept includes the sample first.
        expect_word(8'b00_00_11_01, 3'd2, 2'b10);
        send(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        drain("flushacc");

        // Backpressure: 16 samples fill four words, 17th is refused.
        d = '0;
        for (int i = 0; i < 16; i++) begin
            xi = 1'((i & 1) ^ ((i >> 3) & 1));
            yi = 1'((i >> 2) & 1);
            d  = d | (8'({yi, xi}) << (2 * (i % 4)));
            if (i % 4 == 3) begin
                expect_word(d, 3'd4, 2'b10);
                d = '0;
            end
            send(2'b10, xi, yi, 1'b0, 1'b1);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        send(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        do_flush();
        check("full_x_count", 32'(x_count), 32'(exp_x));
        check("full_y_count", 32'(y_count), 32'(exp_y));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_in_ready", 32'(in_ready), 32'd1);
        drain("bp");

        // Saturation on the 3-bit-counter instance.
        s_in_valid = 1'b1; s_x = 1'b1; s_y = 1'b0; s_sel = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check("sat_x_count", 32'(s_x_count), 32'd7);
        check("sat_y_count", 32'(s_y_count), 32'd0);

        // Mid-operation reset discards buffered and partial words.
        expect_word(8'h55, 3'd4, 2'b01);
        for (int i = 0; i < 4; i++) send(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        send(2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_x_count", 32'(x_count), 32'd0);
        check("mid_rst_y_count", 32'(y_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_len", 32'(out_len), 32'd0);
        q.delete();
        exp_x = 0;
        exp_y = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        expect_word(8'hC1, 3'd4, 2'b10);
        send(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        send(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        send(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
        send(2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        check("post_rst_x_count", 32'(x_count), 32'd2);
        check("post_rst_y_count", 32'(y_count), 32'd1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
